// File: rtl/traffic_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : traffic_cfg_sequencer
// Brief   : Turns host power/config requests into the traffic light's command sequence.
// Revision: 1.0
// ============================================================================
module traffic_cfg_sequencer #(
    parameter int DEF_RED_MS    = 10,
    parameter int DEF_YELLOW_MS = 3,
    parameter int DEF_GREEN_MS  = 8,
    parameter int MAX_MS        = 1000,
    parameter int CMD_GAP       = 2
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [15:0] req_red_i,
    input  logic [15:0] req_yellow_i,
    input  logic [15:0] req_green_i,
    output logic [2:0]  cmd_type_o,
    output logic        cmd_valid_o,
    output logic [15:0] cmd_data_o,
    output logic [1:0]  mode_o,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [1:0]  c_mode_off   = 2'd0;
    localparam logic [1:0]  c_mode_blink = 2'd1;
    localparam logic [1:0]  c_mode_run   = 2'd2;
    localparam logic [1:0]  c_op_on      = 2'd0;
    localparam logic [1:0]  c_op_off     = 2'd1;
    localparam logic [1:0]  c_op_cfg     = 2'd2;
    localparam logic [15:0] c_max_ms     = 16'(MAX_MS);
    localparam logic [3:0]  c_gap_last   = 4'(CMD_GAP - 1);

    state_t      r_state;
    logic [4:0]  r_mask;
    logic [2:0]  r_pre_type;
    logic [1:0]  r_final_mode;
    logic [3:0]  r_gap_cnt;
    logic [15:0] r_red, r_yellow, r_green;
    logic [2:0]  r_cmd_type;
    logic        r_cmd_valid;
    logic [15:0] r_cmd_data;
    logic [1:0]  r_mode;
    logic        r_err;

    logic        w_accept, w_cfg_ok, w_cfg_load, w_reject;
    logic [4:0]  w_mask, w_sel_mask, w_rem_mask;
    logic [2:0]  w_pre_type, w_sel_pre, w_step, w_step_type;
    logic [1:0]  w_final_mode;
    logic [15:0] w_sel_red, w_sel_yellow, w_sel_green, w_step_data;

    // Steps are mask bits 0..4: PRE, CFG_R, CFG_Y, CFG_G, POST; lowest set bit goes next.
    function automatic logic [2:0] f_first_step(input logic [4:0] m);
        f_first_step = 3'd5;
        for (int i = 4; i >= 0; i--) begin
            if (m[i]) f_first_step = 3'(i);
        end
    endfunction

    assign w_accept   = req_valid_i && (r_state == ST_IDLE);
    assign w_cfg_ok   = (req_red_i != 16'd0)    && (req_red_i <= c_max_ms) &&
                        (req_yellow_i != 16'd0) && (req_yellow_i <= c_max_ms) &&
                        (req_green_i != 16'd0)  && (req_green_i <= c_max_ms);
    assign w_cfg_load = (req_op_i == c_op_cfg) && w_cfg_ok;
    assign w_reject   = (req_op_i == c_op_cfg) && !w_cfg_ok;

    always_comb begin
        w_mask       = 5'b00000;
        w_pre_type   = 3'd0;
        w_final_mode = r_mode;
        case (req_op_i)
            c_op_on: begin
                w_final_mode = c_mode_run;
                if (r_mode == c_mode_off)        w_mask = 5'b11111;
                else if (r_mode == c_mode_blink) w_mask = 5'b11110;
            end
            c_op_off: begin
                w_final_mode = c_mode_off;
                w_pre_type   = 3'd1;
                if (r_mode != c_mode_off) w_mask = 5'b00001;
            end
            c_op_cfg: begin
                w_pre_type = 3'd2;
                if (w_cfg_ok) begin
                    if (r_mode == c_mode_blink)    w_mask = 5'b01110;
                    else if (r_mode == c_mode_run) w_mask = 5'b11111;
                end
            end
            default: begin
                w_final_mode = c_mode_blink;
                if (r_mode == c_mode_run) begin
                    w_mask     = 5'b00001;
                    w_pre_type = 3'd2;
                end else if (r_mode == c_mode_off) begin
                    w_mask = 5'b01111;
                end
            end
        endcase
    end

    // The first command leaves on the same edge that loads the shadows, so bypass them.
    assign w_sel_mask   = (r_state == ST_IDLE) ? w_mask     : r_mask;
    assign w_sel_pre    = (r_state == ST_IDLE) ? w_pre_type : r_pre_type;
    assign w_sel_red    = (r_state == ST_IDLE && w_cfg_load) ? req_red_i    : r_red;
    assign w_sel_yellow = (r_state == ST_IDLE && w_cfg_load) ? req_yellow_i : r_yellow;
    assign w_sel_green  = (r_state == ST_IDLE && w_cfg_load) ? req_green_i  : r_green;
    assign w_step       = f_first_step(w_sel_mask);
    assign w_rem_mask   = w_sel_mask & ~(5'd1 << w_step);

    always_comb begin
        w_step_type = 3'd0;
        w_step_data = 16'd0;
        case (w_step)
            3'd0:    w_step_type = w_sel_pre;
            3'd1:    begin w_step_type = 3'd4; w_step_data = w_sel_red;    end
            3'd2:    begin w_step_type = 3'd5; w_step_data = w_sel_yellow; end
            3'd3:    begin w_step_type = 3'd3; w_step_data = w_sel_green;  end
            default: begin w_step_type = 3'd0; w_step_data = 16'd0;        end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state      <= ST_IDLE;
            r_mask       <= 5'b00000;
            r_pre_type   <= 3'd0;
            r_final_mode <= c_mode_off;
            r_gap_cnt    <= 4'd0;
            r_red        <= 16'(DEF_RED_MS);
            r_yellow     <= 16'(DEF_YELLOW_MS);
            r_green      <= 16'(DEF_GREEN_MS);
            r_cmd_type   <= 3'd0;
            r_cmd_valid  <= 1'b0;
            r_cmd_data   <= 16'd0;
            r_mode       <= c_mode_off;
            r_err        <= 1'b0;
        end else begin
            r_err       <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_type  <= 3'd0;
            r_cmd_data  <= 16'd0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_cfg_load) begin
                            r_red    <= req_red_i;
                            r_yellow <= req_yellow_i;
                            r_green  <= req_green_i;
                        end
                        r_err      <= w_reject;
                        r_pre_type <= w_pre_type;
                        if (w_mask != 5'b00000) begin
                            r_state      <= ST_ISSUE;
                            r_cmd_valid  <= 1'b1;
                            r_cmd_type   <= w_step_type;
                            r_cmd_data   <= w_step_data;
                            r_mask       <= w_rem_mask;
                            r_final_mode <= w_final_mode;
                        end else begin
                            r_mode <= w_final_mode;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_state   <= ST_GAP;
                    r_gap_cnt <= c_gap_last;
                end
                ST_GAP: begin
                    if (r_gap_cnt != 4'd0) begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end else if (r_mask != 5'b00000) begin
                        r_state     <= ST_ISSUE;
                        r_cmd_valid <= 1'b1;
                        r_cmd_type  <= w_step_type;
                        r_cmd_data  <= w_step_data;
                        r_mask      <= w_rem_mask;
                    end else begin
                        r_state <= ST_IDLE;
                        r_mode  <= r_final_mode;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o = (r_state == ST_IDLE);
    assign busy_o      = (r_state != ST_IDLE);
    assign cmd_type_o  = r_cmd_type;
    assign cmd_valid_o = r_cmd_valid;
    assign cmd_data_o  = r_cmd_data;
    assign mode_o      = r_mode;
    assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_traffic_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_traffic_cfg_sequencer
// Brief   : Directed self-checking bench for traffic_cfg_sequencer (CMD_GAP = 2).
// Revision: 1.0
// ============================================================================
module tb_traffic_cfg_sequencer;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [15:0] req_red = 16'd0, req_yellow = 16'd0, req_green = 16'd0;
    logic [2:0]  cmd_type;
    logic        cmd_valid;
    logic [15:0] cmd_data;
    logic [1:0]  mode;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Observations from the most recent run_req call.
    int          npulse;
    int          pulse_cyc [8];
    logic [2:0]  pulse_type [8];
    logic [15:0] pulse_data [8];
    int          err_seen, err_cyc, done_cyc;
    logic        mode_mid, busy_bad;

    traffic_cfg_sequencer #(
        .DEF_RED_MS(10), .DEF_YELLOW_MS(3), .DEF_GREEN_MS(8), .MAX_MS(1000), .CMD_GAP(2)
    ) dut (
        .clk_i(clk), .arst_i(arst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_red_i(req_red), .req_yellow_i(req_yellow), .req_green_i(req_green),
        .cmd_type_o(cmd_type), .cmd_valid_o(cmd_valid), .cmd_data_o(cmd_data),
        .mode_o(mode), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    // Presents one request in cycle 0 and records cycle-indexed activity until IDLE.
    task automatic run_req(input logic [1:0] op, input logic [15:0] r, input logic [15:0] y,
                           input logic [15:0] g);
        logic [1:0] m0;
        @(negedge clk);
        m0 = mode;
        req_op = op; req_red = r; req_yellow = y; req_green = g; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        npulse = 0; err_seen = 0; err_cyc = -1; done_cyc = -1; mode_mid = 1'b0; busy_bad = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (cmd_valid === 1'b1) begin
                if (npulse < 8) begin
                    pulse_cyc[npulse] = c; pulse_type[npulse] = cmd_type; pulse_data[npulse] = cmd_data;
                end
                npulse++;
            end
            if (err === 1'b1) begin
                err_seen++;
                if (err_cyc < 0) err_cyc = c;
            end
            if (busy !== !req_ready) busy_bad = 1'b1;
            if (req_ready === 1'b1) begin
                done_cyc = c;
                break;
            end
            if (mode !== m0) mode_mid = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (cmd_valid !== 1'b0 || cmd_type !== 3'd0 || cmd_data !== 16'd0 || err !== 1'b0 ||
            busy !== 1'b0 || req_ready !== 1'b1 || mode !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b type=%0d data=%0d err=%b busy=%b ready=%b mode=%0d, required 0 0 0 0 0 1 0",
                     cmd_valid, cmd_type, cmd_data, err, busy, req_ready, mode);
        end
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic test_power_on_from_off();
        int et[5] = '{0, 4, 5, 3, 0};
        int ed[5] = '{0, 10, 3, 8, 0};
        run_req(2'd0, 16'd0, 16'd0, 16'd0);
        checks++;
        if (npulse != 5 || done_cyc != 16 || mode !== 2'd2 || mode_mid || busy_bad) begin
            errors++;
            $display("FAIL power_on_seq: pulses=%0d done=%0d mode=%0d mid=%b busybad=%b, required 5 16 2 0 0",
                     npulse, done_cyc, mode, mode_mid, busy_bad);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (pulse_cyc[k] != 1 + 3 * k || pulse_type[k] !== 3'(et[k]) || pulse_data[k] !== 16'(ed[k])) begin
                errors++;
                $display("FAIL power_on_pulse%0d: cyc=%0d type=%0d data=%0d, required %0d %0d %0d",
                         k, pulse_cyc[k], pulse_type[k], pulse_data[k], 1 + 3 * k, et[k], ed[k]);
            end
        end
    endtask

    task automatic test_reconfig_run();
        int et[5] = '{2, 4, 5, 3, 0};
        int ed[5] = '{0, 20, 4, 12, 0};
        run_req(2'd2, 16'd20, 16'd4, 16'd12);
        checks++;
        if (npulse != 5 || done_cyc != 16 || mode !== 2'd2 || mode_mid || err_seen != 0) begin
            errors++;
            $display("FAIL reconfig_run_seq: pulses=%0d done=%0d mode=%0d mid=%b err=%0d, required 5 16 2 0 0",
                     npulse, done_cyc, mode, mode_mid, err_seen);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (pulse_cyc[k] != 1 + 3 * k || pulse_type[k] !== 3'(et[k]) || pulse_data[k] !== 16'(ed[k])) begin
                errors++;
                $display("FAIL reconfig_pulse%0d: cyc=%0d type=%0d data=%0d, required %0d %0d %0d",
                         k, pulse_cyc[k], pulse_type[k], pulse_data[k], 1 + 3 * k, et[k], ed[k]);
            end
        end
        run_req(2'd0, 16'd0, 16'd0, 16'd0);
        checks++;
        if (npulse != 0 || done_cyc != 1 || mode !== 2'd2) begin
            errors++;
            $display("FAIL power_on_in_run: pulses=%0d done=%0d mode=%0d, required 0 1 2", npulse, done_cyc, mode);
        end
    endtask

    task automatic test_reject();
        logic [15:0] bad_green[2] = '{16'd0, 16'd1001};
        for (int i = 0; i < 2; i++) begin
            run_req(2'd2, 16'd30, 16'd5, bad_green[i]);
            checks++;
            if (err_seen != 1 || err_cyc != 1 || npulse != 0 || done_cyc != 1 || mode !== 2'd2) begin
                errors++;
                $display("FAIL reject_green%0d: errs=%0d errcyc=%0d pulses=%0d done=%0d mode=%0d, required 1 1 0 1 2",
                         bad_green[i], err_seen, err_cyc, npulse, done_cyc, mode);
            end
            @(posedge clk); #1;
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL reject_pulse_width: err=%b, required 0", err);
            end
        end
    endtask

    task automatic test_blink_off();
        // RUN -> FORCE_BLINK: single PRE=2.
        run_req(2'd3, 16'd0, 16'd0, 16'd0);
        checks++;
        if (npulse != 1 || pulse_type[0] !== 3'd2 || pulse_data[0] !== 16'd0 || done_cyc != 4 ||
            mode !== 2'd1 || mode_mid) begin
            errors++;
            $display("FAIL force_blink_run: pulses=%0d type=%0d done=%0d mode=%0d mid=%b, required 1 2 4 1 0",
                     npulse, pulse_type[0], done_cyc, mode, mode_mid);
        end
        // BLINK -> POWER_OFF: single PRE=1.
        run_req(2'd1, 16'd0, 16'd0, 16'd0);
        checks++;
        if (npulse != 1 || pulse_type[0] !== 3'd1 || done_cyc != 4 || mode !== 2'd0) begin
            errors++;
            $display("FAIL power_off_blink: pulses=%0d type=%0d done=%0d mode=%0d, required 1 1 4 0",
                     npulse, pulse_type[0], done_cyc, mode);
        end
        // OFF -> POWER_ON must carry the 20/4/12 shadows; rejects left them alone.
        run_req(2'd0, 16'd0, 16'd0, 16'd0);
        checks++;
        if (npulse != 5 || pulse_data[1] !== 16'd20 || pulse_data[2] !== 16'd4 || pulse_data[3] !== 16'd12 ||
            mode !== 2'd2) begin
            errors++;
            $display("FAIL shadows_after_reject: pulses=%0d data=%0d/%0d/%0d mode=%0d, required 5 20/4/12 2",
                     npulse, pulse_data[1], pulse_data[2], pulse_data[3], mode);
        end
        run_req(2'd1, 16'd0, 16'd0, 16'd0);
        // OFF -> FORCE_BLINK: PRE=0 then CFG_R/Y/G.
        run_req(2'd3, 16'd0, 16'd0, 16'd0);
        checks++;
        if (npulse != 4 || pulse_type[0] !== 3'd0 || pulse_type[1] !== 3'd4 || pulse_type[3] !== 3'd3 ||
            pulse_data[3] !== 16'd12 || done_cyc != 13 || mode !== 2'd1) begin
            errors++;
            $display("FAIL force_blink_off: pulses=%0d t0=%0d t1=%0d t3=%0d d3=%0d done=%0d mode=%0d, required 4 0 4 3 12 13 1",
                     npulse, pulse_type[0], pulse_type[1], pulse_type[3], pulse_data[3], done_cyc, mode);
        end
        // BLINK -> RECONFIG: CFG only, new values.
        run_req(2'd2, 16'd50, 16'd6, 16'd1000);
        checks++;
        if (npulse != 3 || pulse_type[0] !== 3'd4 || pulse_data[0] !== 16'd50 || pulse_type[1] !== 3'd5 ||
            pulse_data[1] !== 16'd6 || pulse_type[2] !== 3'd3 || pulse_data[2] !== 16'd1000 ||
            done_cyc != 10 || mode !== 2'd1 || err_seen != 0) begin
            errors++;
            $display("FAIL reconfig_blink: pulses=%0d %0d/%0d %0d/%0d %0d/%0d done=%0d mode=%0d, required 3 4/50 5/6 3/1000 10 1",
                     npulse, pulse_type[0], pulse_data[0], pulse_type[1], pulse_data[1],
                     pulse_type[2], pulse_data[2], done_cyc, mode);
        end
        // BLINK -> POWER_ON: CFG_R/Y/G then POST.
        run_req(2'd0, 16'd0, 16'd0, 16'd0);
        checks++;
        if (npulse != 4 || pulse_type[0] !== 3'd4 || pulse_type[3] !== 3'd0 || pulse_data[0] !== 16'd50 ||
            done_cyc != 13 || mode !== 2'd2) begin
            errors++;
            $display("FAIL power_on_blink: pulses=%0d t0=%0d t3=%0d d0=%0d done=%0d mode=%0d, required 4 4 0 50 13 2",
                     npulse, pulse_type[0], pulse_type[3], pulse_data[0], done_cyc, mode);
        end
    endtask

    task automatic test_reset_mid();
        int et[5] = '{0, 4, 5, 3, 0};
        int ed[5] = '{0, 10, 3, 8, 0};
        run_req(2'd3, 16'd0, 16'd0, 16'd0);
        @(negedge clk);
        req_op = 2'd0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        // BLINK start: CFG_R at cycle 1, CFG_Y at 4, GAP at 5.
        repeat (4) @(posedge clk);
        #1;
        arst = 1'b1;
        #1;
        checks++;
        if (cmd_valid !== 1'b0 || cmd_type !== 3'd0 || cmd_data !== 16'd0 || err !== 1'b0 ||
            busy !== 1'b0 || req_ready !== 1'b1 || mode !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: valid=%b type=%0d data=%0d err=%b busy=%b ready=%b mode=%0d, required 0 0 0 0 0 1 0",
                     cmd_valid, cmd_type, cmd_data, err, busy, req_ready, mode);
        end
        @(negedge clk);
        arst = 1'b0;
        run_req(2'd0, 16'd0, 16'd0, 16'd0);
        checks++;
        if (npulse != 5 || done_cyc != 16 || mode !== 2'd2) begin
            errors++;
            $display("FAIL reset_mid_rerun: pulses=%0d done=%0d mode=%0d, required 5 16 2", npulse, done_cyc, mode);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (pulse_type[k] !== 3'(et[k]) || pulse_data[k] !== 16'(ed[k])) begin
                errors++;
                $display("FAIL reset_mid_pulse%0d: type=%0d data=%0d, required %0d %0d",
                         k, pulse_type[k], pulse_data[k], et[k], ed[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int first_ready = -1;
        int n_total = 0;
        int n_off = 0;
        logic ready_bad = 1'b0;
        @(negedge clk);
        req_op = 2'd2; req_red = 16'd7; req_yellow = 16'd7; req_green = 16'd7; req_valid = 1'b1;
        @(posedge clk); #1;
        req_op = 2'd1;
        for (int c = 1; c <= 30; c++) begin
            if (cmd_valid === 1'b1) begin
                n_total++;
                if (cmd_type === 3'd1) n_off++;
            end
            if (first_ready < 0) begin
                if (req_ready === 1'b1) first_ready = c;
                else if (req_ready !== 1'b0) ready_bad = 1'b1;
            end
            @(posedge clk); #1;
            if (first_ready > 0) req_valid = 1'b0;
        end
        checks++;
        if (first_ready != 16 || ready_bad) begin
            errors++;
            $display("FAIL held_ready: first_ready=%0d bad=%b, required 16 0", first_ready, ready_bad);
        end
        checks++;
        if (n_total != 6 || n_off != 1 || mode !== 2'd0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL held_accept_once: total=%0d off=%0d mode=%0d ready=%b, required 6 1 0 1",
                     n_total, n_off, mode, req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_power_on_from_off();
        test_reconfig_run();
        test_reject();
        test_blink_off();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
